spi_reg_ctrl: RTL

Command/register-access controller behind the SPI bridge of the PWM generator. It decodes the byte stream delivered by the bridge (`byte_sync`/`data_in`) into register reads and writes, supplies the bridge's `data_out` for read-back, and supports single and auto-increment burst accesses. It is the only master of the PWM register file and runs entirely in the `clk` domain, except for the `cs_n` input, which it synchronises internally.

---
 rtl/pwm_spi_pkg.sv | 15 +
 rtl/sync_ff.sv | 21 ++
 rtl/spi_reg_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pwm_spi_pkg.sv
// Shared definitions for the PWM generator's SPI register-access path.
package pwm_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_DATA = 2'd1,
    ST_RD_DATA = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int          CMD_WR_BIT    = 7;
  localparam int          CMD_BURST_BIT = 6;
  localparam logic [7:0]  DUMMY_BYTE    = 8'h00;

endpackage

// File: rtl/sync_ff.sv
// N-flop synchroniser for a single asynchronous level; flops preset to RST_VAL.
module sync_ff #(
  parameter int   N       = 3,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= {N{RST_VAL}};
    else        ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/spi_reg_ctrl.sv
// Decodes SPI bridge bytes into register reads/writes with single and
// auto-increment burst access; sole master of the PWM register file.
module spi_reg_ctrl
  import pwm_spi_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              addr_err
);

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  state_e            state_q, state_d;
  logic              burst_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] acc_addr;
  logic              in_range;
  logic              ld_cmd, do_we, do_re, clr_dout;
  logic              cs_s, cs_q, frame_end, end_pend, rd_pend;

  sync_ff #(.N(3), .RST_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cs_n),
    .q     (cs_s)
  );

  assign frame_end = cs_s & ~cs_q;

  // The command byte carries its own address; data bytes use the running pointer.
  assign acc_addr = (state_q == ST_IDLE) ? data_in[ADDR_W-1:0] : cur_addr;
  assign in_range = {1'b0, acc_addr} < NUM_REGS_W;

  always_comb begin
    state_d  = state_q;
    ld_cmd   = 1'b0;
    do_we    = 1'b0;
    do_re    = 1'b0;
    clr_dout = 1'b0;
    if (end_pend) begin
      state_d = ST_IDLE;
    end else if (byte_sync) begin
      unique case (state_q)
        ST_IDLE: begin
          ld_cmd = 1'b1;
          if (data_in[CMD_WR_BIT]) begin
            state_d = ST_WR_DATA;
          end else begin
            do_re   = 1'b1;
            state_d = ST_RD_DATA;
          end
        end
        ST_WR_DATA: begin
          do_we = 1'b1;
          if (!burst_q) state_d = ST_DONE;
        end
        ST_RD_DATA: begin
          if (burst_q) begin
            do_re = 1'b1;
          end else begin
            clr_dout = 1'b1;
            state_d  = ST_DONE;
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end else if (frame_end) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cs_q      <= 1'b1;
      end_pend  <= 1'b0;
      rd_pend   <= 1'b0;
      burst_q   <= 1'b0;
      cur_addr  <= '0;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      addr_err  <= 1'b0;
      data_out  <= DUMMY_BYTE;
    end else begin
      state_q  <= state_d;
      cs_q     <= cs_s;
      // A byte landing with the frame end is still processed; IDLE follows.
      end_pend <= frame_end & byte_sync;
      rd_pend  <= do_re;
      reg_we   <= do_we & in_range;
      reg_re   <= do_re & in_range;
      addr_err <= (do_we | do_re) & ~in_range;

      if (ld_cmd) begin
        burst_q  <= data_in[CMD_BURST_BIT];
        cur_addr <= data_in[ADDR_W-1:0];
      end
      if (do_we | do_re) begin
        reg_addr <= acc_addr;
        cur_addr <= acc_addr + 1'b1;
      end
      if (do_we) reg_wdata <= data_in;

      if (clr_dout || end_pend || (frame_end && !byte_sync))
        data_out <= DUMMY_BYTE;
      else if (rd_pend)
        data_out <= reg_re ? reg_rdata : DUMMY_BYTE;
    end
  end

endmodule
